run_expand: RTL and testbench
=============================

RUN_EXPAND -- requirements
Module: run_expand

Interface
REQ-001 The block SHALL have parameter LEN_W, default 4, giving the width of the run-length field.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a run token is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a token this cycle.
REQ-006 The block SHALL have port in_bit, input, 1 bit: the value of the run.
REQ-007 The block SHALL have port in_len, input, LEN_W bits: run length minus one (0 means a 1-cycle run).
REQ-008 The block SHALL have port out, output, 1 bit: the serial bit stream.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out carries a run bit this cycle.
REQ-010 The block SHALL have port run_last, output, 1 bit: this cycle carries the final bit of the current run.

Function
REQ-011 A token SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_ready SHALL equal NOT hold_valid.
REQ-012 The state machine SHALL have states IDLE (out_valid=0) and RUN (out_valid=1); the remaining storage is cur_bit, cnt[LEN_W-1:0], hold_valid, hold_bit and hold_len.
REQ-013 In IDLE, an accepted token SHALL load cur_bit=in_bit and cnt=in_len and enter RUN on the same edge, so the first run bit is on out in the cycle directly after acceptance (latency 1).
REQ-014 In RUN, out SHALL equal cur_bit; in IDLE, out SHALL be 0.
REQ-015 Each token SHALL produce exactly in_len+1 consecutive cycles of out_valid=1 with out=in_bit.
REQ-016 In RUN with cnt>0, cnt SHALL decrement by 1 per cycle; the counter SHALL never wrap below 0.
REQ-017 run_last SHALL be 1 exactly when state=RUN and cnt=0, and 0 otherwise.
REQ-018 In RUN with cnt>0, an accepted token SHALL be stored in the hold register (hold_valid=1).
REQ-019 In RUN with cnt=0 and hold_valid=1, the next edge SHALL move the hold register into cur_bit/cnt, clear hold_valid and stay in RUN, giving no idle bubble.
REQ-020 In RUN with cnt=0, hold_valid=0 and an accepted token, that token SHALL load directly into cur_bit/cnt, bypassing hold, and the state SHALL stay RUN.
REQ-021 In RUN with cnt=0, hold_valid=0 and no acceptance, the state SHALL return to IDLE.
REQ-022 Tokens SHALL be emitted strictly in acceptance order; with hold full, in_ready=0 and in_valid SHALL be ignored without loss of held data.
REQ-023 Consecutive runs with equal in_bit SHALL appear on out as one merged stream, with run_last marking each token boundary.
REQ-024 in_bit and in_len SHALL be sampled only on the accepting edge; later changes on them SHALL have no effect.

Reset
REQ-025 While reset=0, the block SHALL asynchronously force state=IDLE, cnt=0, cur_bit=0, hold_valid=0, hold_bit=0 and hold_len=0; out, out_valid and run_last SHALL be 0 and in_ready SHALL be 1.
REQ-026 Reset asserted mid-run SHALL discard the current run and any held token; no partial bits SHALL appear after reset is released.
REQ-027 No token SHALL be accepted on any edge while reset=0; the first acceptance SHALL be possible on the first rising edge after reset returns to 1.

Verification
REQ-028 Reset check: assert reset=0 for 3 cycles, then release -> out=0, out_valid=0, run_last=0 and in_ready=1 throughout.
REQ-029 Single run: token bit=1, len=2 accepted at edge E -> out=1 with out_valid=1 for exactly 3 cycles after E, run_last=1 in the 3rd cycle, then IDLE.
REQ-030 Back-to-back runs: token (1,len=1) then (0,len=0) offered while the first is running -> out sequence 1,1,0 with no gap, run_last=1 in cycles 2 and 3, and in_ready=0 while hold is full.
REQ-031 Direct bypass: offer token (0,len=3) exactly in the run_last cycle of a (1,len=0) run -> out 1,0,0,0,0 contiguous, with hold_valid remaining 0.
REQ-032 Maximum length and backpressure: token (1,len=15) with a second and third token offered continuously -> 16 ones, the second token follows immediately, the third is accepted only after hold drains, and the counter does not wrap.
REQ-033 Mid-run reset: reset=0 in the 2nd cycle of a (1,len=7) run with hold full -> out_valid=0 at once, and no remaining bits are emitted after release.

Source files
------------

// File: rtl/run_expand.sv
// Run-length expander: each (bit, len) token becomes len+1 serial cycles of that
// bit. A one-deep hold register lets the next token follow with no idle bubble.
module run_expand #(
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_bit,
   input  logic [LEN_W-1:0] in_len,
   output logic             out,
   output logic             out_valid,
   output logic             run_last
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t             state_q, state_d;
   logic               cur_bit_q, cur_bit_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic               hold_valid_q, hold_valid_d;
   logic               hold_bit_q, hold_bit_d;
   logic [LEN_W-1:0]   hold_len_q, hold_len_d;
   logic               accept;
   logic               cnt_zero;

   assign in_ready  = ~hold_valid_q;
   assign accept    = in_valid & in_ready;
   assign cnt_zero  = (cnt_q == '0);
   assign out_valid = (state_q == RUN);
   assign out       = (state_q == RUN) & cur_bit_q;
   assign run_last  = (state_q == RUN) & cnt_zero;

   always_comb begin
      state_d      = state_q;
      cur_bit_d    = cur_bit_q;
      cnt_d        = cnt_q;
      hold_valid_d = hold_valid_q;
      hold_bit_d   = hold_bit_q;
      hold_len_d   = hold_len_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               cur_bit_d = in_bit;
               cnt_d     = in_len;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - LEN_W'(1);
               if (accept) begin
                  hold_valid_d = 1'b1;
                  hold_bit_d   = in_bit;
                  hold_len_d   = in_len;
               end
            end else if (hold_valid_q) begin
               // in_ready is low here, so no new token can race the held one
               cur_bit_d    = hold_bit_q;
               cnt_d        = hold_len_q;
               hold_valid_d = 1'b0;
            end else if (accept) begin
               cur_bit_d = in_bit;
               cnt_d     = in_len;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cur_bit_q    <= 1'b0;
         cnt_q        <= '0;
         hold_valid_q <= 1'b0;
         hold_bit_q   <= 1'b0;
         hold_len_q   <= '0;
      end else begin
         state_q      <= state_d;
         cur_bit_q    <= cur_bit_d;
         cnt_q        <= cnt_d;
         hold_valid_q <= hold_valid_d;
         hold_bit_q   <= hold_bit_d;
         hold_len_q   <= hold_len_d;
      end
   end

endmodule

// File: tb/tb_run_expand.sv
// Directed bench for run_expand: hand-computed out/out_valid/run_last/in_ready
// per cycle, sampled 1 time unit after each rising edge.
module tb_run_expand;
   localparam int LEN_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic             in_bit;
   logic [LEN_W-1:0] in_len;
   logic             out;
   logic             out_valid;
   logic             run_last;

   int errors = 0;
   int checks = 0;

   run_expand #(.LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_bit(in_bit), .in_len(in_len), .out(out), .out_valid(out_valid),
      .run_last(run_last)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic e_out, input logic e_vld,
                      input logic e_last, input logic e_rdy);
      logic [3:0] got, exp;
      got = {out, out_valid, run_last, in_ready};
      exp = {e_out, e_vld, e_last, e_rdy};
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: {out,vld,last,rdy} got=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic offer(input logic v, input logic b, input int l);
      in_valid = v;
      in_bit   = b;
      in_len   = LEN_W'(l);
   endtask

   initial begin
      reset = 1'b0;
      offer(0, 0, 0);
      #2;
      chk("reset_async", 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_hold", 0, 0, 0, 1);
      end
      reset = 1'b1;
      tick();
      chk("reset_release", 0, 0, 0, 1);

      // single run, len=2; input changes after acceptance must be ignored
      offer(1, 1, 2);
      tick();
      offer(0, 0, 7);
      chk("single_c1", 1, 1, 0, 1);
      tick(); chk("single_c2", 1, 1, 0, 1);
      tick(); chk("single_c3", 1, 1, 1, 1);
      tick(); chk("single_idle", 0, 0, 0, 1);

      // back-to-back: (1,len1) then (0,len0) into hold
      offer(1, 1, 1);
      tick(); chk("b2b_c1", 1, 1, 0, 1);
      offer(1, 0, 0);
      tick(); chk("b2b_c2", 1, 1, 1, 0);
      offer(0, 1, 5);
      tick(); chk("b2b_c3", 0, 1, 1, 1);
      tick(); chk("b2b_idle", 0, 0, 0, 1);

      // bypass in the run_last cycle
      offer(1, 1, 0);
      tick(); chk("byp_c1", 1, 1, 1, 1);
      offer(1, 0, 3);
      tick(); chk("byp_c2", 0, 1, 0, 1);
      offer(0, 0, 0);
      tick(); chk("byp_c3", 0, 1, 0, 1);
      tick(); chk("byp_c4", 0, 1, 0, 1);
      tick(); chk("byp_c5", 0, 1, 1, 1);
      tick(); chk("byp_idle", 0, 0, 0, 1);

      // max length with backpressure: A=(1,15), B=(0,1), C=(1,0)
      offer(1, 1, 15);
      tick(); chk("max_one_1", 1, 1, 0, 1);
      offer(1, 0, 1);
      tick(); chk("max_one_2", 1, 1, 0, 0);
      offer(1, 1, 0);
      for (int i = 3; i <= 16; i++) begin
         tick();
         chk($sformatf("max_one_%0d", i), 1, 1, (i == 16), 0);
      end
      tick(); chk("max_b_c1", 0, 1, 0, 1);
      tick(); chk("max_b_c2", 0, 1, 1, 0);
      offer(0, 0, 0);
      tick(); chk("max_c", 1, 1, 1, 1);
      tick(); chk("max_idle", 0, 0, 0, 1);

      // mid-run reset with hold full
      offer(1, 1, 7);
      tick(); chk("mrst_c1", 1, 1, 0, 1);
      offer(1, 0, 2);
      tick(); chk("mrst_c2", 1, 1, 0, 0);
      offer(1, 1, 0);
      #1 reset = 1'b0;
      #1 chk("mrst_async", 0, 0, 0, 1);
      tick(); chk("mrst_no_accept", 0, 0, 0, 1);
      offer(0, 0, 0);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mrst_after", 0, 0, 0, 1);
      end

      // first acceptance after release works normally
      offer(1, 0, 0);
      tick(); chk("post_rst_c1", 0, 1, 1, 1);
      offer(0, 0, 0);
      tick(); chk("post_rst_idle", 0, 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
